// File: rtl/overlay_pkg.sv
// Shared types and screen constants for the title overlay and future sprite overlays.
package overlay_pkg;
    typedef enum logic [2:0] {IDLE, SLIDE_IN, HOLD, EXIT, DONE} overlay_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
endpackage

// File: rtl/overlay_addr_pipe.sv
// Rectangular sprite hit test and row-major ROM address generator.
// Latency: 2 cycles from draw_x/draw_y to hit/addr.
// Backpressure: none; free-running with the pixel scan, cleared while en is low.
module overlay_addr_pipe
    import overlay_pkg::*;
#(
    parameter int W      = 480,
    parameter int H      = 240,
    parameter int X0     = 80,
    parameter int ADDR_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [9:0]          draw_x,
    input  logic [9:0]          draw_y,
    input  logic signed [10:0]  y_pos,
    output logic                hit,
    output logic [ADDR_W-1:0]   addr
);
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic               hit_c;
    logic               hit_s1;
    logic [11:0]        x_off;
    logic [11:0]        y_off;

    // Signed offsets: a sprite partly above the screen never wraps into large rows.
    always_comb begin
        dx    = $signed({2'b00, draw_x}) - $signed(12'(X0));
        dy    = $signed({2'b00, draw_y}) - $signed({y_pos[10], y_pos});
        hit_c = (dx >= 12'sd0) && (dx < $signed(12'(W))) &&
                (dy >= 12'sd0) && (dy < $signed(12'(H)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_s1 <= 1'b0;
            x_off  <= '0;
            y_off  <= '0;
            hit    <= 1'b0;
            addr   <= '0;
        end else if (!en) begin
            hit_s1 <= 1'b0;
            x_off  <= '0;
            y_off  <= '0;
            hit    <= 1'b0;
            addr   <= '0;
        end else begin
            hit_s1 <= hit_c;
            x_off  <= hit_c ? dx : '0;
            y_off  <= hit_c ? dy : '0;
            hit    <= hit_s1;
            addr   <= hit_s1 ? ADDR_W'(y_off) * ADDR_W'(W) + ADDR_W'(x_off) : '0;
        end
    end
endmodule

// File: rtl/title_overlay.sv
// Animated title logo overlay: slide in, blink "press start", slide out, report done.
// Latency: 2 cycles DrawX/DrawY to is_logo/logo_address; done one cycle after last frame_start.
// Backpressure: none; follows the VGA scan and frame_start strobes.
module title_overlay
    import overlay_pkg::*;
#(
    parameter int LOGO_W       = 480,
    parameter int LOGO_H       = 240,
    parameter int X0           = 80,
    parameter int Y_FINAL      = 60,
    parameter int Y_START      = -240,
    parameter int SLIDE_STEP   = 4,
    parameter int BLINK_FRAMES = 32,
    parameter int LEVEL_TITLE  = 0,
    parameter int ADDR_W       = 18
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [2:0]        level_num,
    input  logic              start_pressed,
    output logic              is_logo,
    output logic [ADDR_W-1:0] logo_address,
    output logic              blink,
    output logic              done
);
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    overlay_state_t     state, state_n;
    logic signed [10:0] y_pos, y_pos_n;
    logic [CNT_W-1:0]   blink_cnt, blink_cnt_n;
    logic               blink_q, blink_n;
    logic               done_n;
    logic               start_q;
    logic               title;
    logic               en;
    logic signed [11:0] y_up, y_dn, y_bot;

    always_comb begin
        state_n     = state;
        y_pos_n     = y_pos;
        blink_cnt_n = blink_cnt;
        blink_n     = blink_q;
        done_n      = 1'b0;
        title       = (level_num == 3'(LEVEL_TITLE));
        y_up        = $signed({y_pos[10], y_pos}) + $signed(12'(SLIDE_STEP));
        y_dn        = $signed({y_pos[10], y_pos}) - $signed(12'(SLIDE_STEP));
        y_bot       = y_dn + $signed(12'(LOGO_H));

        case (state)
            IDLE: begin
                blink_n = 1'b0;
                if (frame_start && title) begin
                    state_n = SLIDE_IN;
                    y_pos_n = 11'(Y_START);
                end
            end
            SLIDE_IN: begin
                if (!title) begin
                    state_n = IDLE;
                end else if (start_pressed || (frame_start && y_up >= $signed(12'(Y_FINAL)))) begin
                    // The skip takes priority over a coincident frame step.
                    state_n     = HOLD;
                    y_pos_n     = 11'(Y_FINAL);
                    blink_n     = 1'b1;
                    blink_cnt_n = '0;
                end else if (frame_start) begin
                    y_pos_n = y_up[10:0];
                end
            end
            HOLD: begin
                if (!title) begin
                    state_n = IDLE;
                    blink_n = 1'b0;
                end else if (start_pressed && !start_q) begin
                    state_n = EXIT;
                    blink_n = 1'b0;
                end else if (frame_start) begin
                    if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_n = '0;
                        blink_n     = !blink_q;
                    end else begin
                        blink_cnt_n = blink_cnt + CNT_W'(1);
                    end
                end
            end
            EXIT: begin
                if (!title) begin
                    state_n = IDLE;
                end else if (frame_start) begin
                    y_pos_n = y_dn[10:0];
                    if (y_bot <= 12'sd0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!title) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            y_pos     <= 11'(Y_START);
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            done      <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state     <= state_n;
            y_pos     <= y_pos_n;
            blink_cnt <= blink_cnt_n;
            blink_q   <= blink_n;
            done      <= done_n;
            start_q   <= start_pressed;
        end
    end

    assign en    = (state == SLIDE_IN) || (state == HOLD) || (state == EXIT);
    assign blink = blink_q && (state == HOLD);

    overlay_addr_pipe #(
        .W      (LOGO_W),
        .H      (LOGO_H),
        .X0     (X0),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk    (Clk),
        .rst    (Reset),
        .en     (en),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .y_pos  (y_pos),
        .hit    (is_logo),
        .addr   (logo_address)
    );
endmodule

// File: doc/title_overlay.md
# title_overlay

Parametrised, animated successor to the title-screen logo gate. It draws a rectangular sprite, normally the game logo, over the VGA scan with a 2-stage registered address pipeline. It runs a per-frame state machine: slide in from above, hold with a blinking "press start" flag, slide out on start, then report done. It sits between the VGA controller's DrawX/DrawY and the color mapper's ROM/priority mux.

## Interface
Parameters:
- LOGO_W, 480: sprite width in pixels
- LOGO_H, 240: sprite height in pixels
- X0, 80: fixed left edge on screen
- Y_FINAL, 60: resting top edge
- Y_START, -240: top edge at slide-in start (signed)
- SLIDE_STEP, 4: pixels moved per frame while sliding
- BLINK_FRAMES, 32: frames per blink half-period
- LEVEL_TITLE, 0: level_num value that shows the overlay
- ADDR_W, 18: address width; must cover LOGO_W*LOGO_H-1

Ports:
- Clk  in  1  pixel-domain clock
- Reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle strobe at the start of vertical blank
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- level_num  in  3  current level
- start_pressed  in  1  level-sensitive start button, already debounced
- is_logo  out  1  sprite pixel valid; aligned with logo_address
- logo_address  out  ADDR_W  sprite ROM address, row-major
- blink  out  1  "press start" visibility; meaningful only in HOLD
- done  out  1  one-cycle pulse when the exit slide completes

## Operation
- State y_pos is signed 11-bit. It is updated only on frame_start, except for the two immediate cases below.
- Reset: state IDLE, y_pos=Y_START, blink counter 0, and all outputs 0.
- State machine:
  - IDLE: on frame_start with level_num==LEVEL_TITLE, go to SLIDE_IN with y_pos=Y_START.
  - SLIDE_IN: each frame_start, y_pos=min(y_pos+SLIDE_STEP, Y_FINAL). On reaching Y_FINAL, go to HOLD.
  - SLIDE_IN skip: start_pressed sets y_pos=Y_FINAL and goes to HOLD on that cycle, without waiting for a frame.
  - HOLD: y_pos stays fixed. The blink counter increments per frame_start; blink toggles when the counter reaches BLINK_FRAMES-1, and the counter then wraps to 0. A rising edge of start_pressed goes to EXIT. Holding start from the skip does not trigger EXIT.
  - EXIT: each frame_start, y_pos-=SLIDE_STEP. When y_pos+LOGO_H<=0, pulse done and go to DONE.
  - DONE: is_logo stays 0. Go to IDLE once level_num!=LEVEL_TITLE, so the sequence never retriggers without leaving the title level.
- In any state other than IDLE/DONE, level_num!=LEVEL_TITLE forces IDLE on the next cycle. No done pulse is produced in that case.
- Hit test is done in signed arithmetic: DrawX in [X0, X0+LOGO_W) and DrawY in [y_pos, y_pos+LOGO_H), in SLIDE_IN, HOLD or EXIT only.
- Clipping: rows above the screen are never hit. There is no wrap of negative y into large DrawY.
- Address is (DrawY-y_pos)*LOGO_W + (DrawX-X0). It is forced to 0 when not hit.
- blink is 0 outside HOLD and resets to 1 on HOLD entry.

## Timing
- Latency from DrawX/DrawY to is_logo/logo_address is exactly 2 cycles.
  - Stage 1 registers the hit flag and the x/y offsets.
  - Stage 2 registers the multiply-add result.
- A y_pos change on frame_start affects the hit test from the next cycle. Because the change occurs during blanking, there is no tearing mid-frame.
- done is high for exactly 1 cycle, the cycle after the final frame_start of EXIT.
- The forced return to IDLE clears the pipeline. is_logo is 0 within 2 cycles.
- Simultaneous frame_start and start_pressed in SLIDE_IN: the skip wins and y_pos=Y_FINAL.
- Asynchronous Reset mid-slide: outputs drop to 0 immediately and stay 0 until a new IDLE to SLIDE_IN entry.

## Structure
- Package overlay_pkg holds:
  - the overlay_state_t enum: IDLE, SLIDE_IN, HOLD, EXIT, DONE
  - the screen constants SCREEN_W=640 and SCREEN_H=480
- Sub-module overlay_addr_pipe contains the 2-stage hit-test and address pipeline. It takes y_pos and an enable, and is reused for future sprites.
- The top level holds the FSM, y_pos and the blink counter.

## Test plan
- Reset mid-HOLD -> next cycle: is_logo=0, done=0, blink=0, and the state reads back IDLE.
- level_num=0, first frame_start -> SLIDE_IN. After 75 further frame_starts with defaults, y_pos=60 and state HOLD. No frame shows y_pos above 60.
- HOLD, DrawX=80, DrawY=60 -> 2 cycles later is_logo=1, address 0. DrawX=559, DrawY=299 -> address 115199. DrawX=560 or DrawY=300 -> is_logo=0, address 0.
- HOLD, 64 frame_starts -> blink toggles 1→0→1, one change every 32 frames.
- start_pressed pulse in HOLD -> EXIT. After 75 frame_starts y_pos=-240, done is high for 1 cycle, then DONE with is_logo=0. level_num→1 then back to 0 -> a new slide begins.
- start_pressed during SLIDE_IN at y_pos=-100 -> HOLD immediately at y_pos=60, with no EXIT while start is held. Separately, level_num→2 during EXIT -> IDLE with no done pulse.
